// File: rtl/tcr_pkg.sv
// Shared field positions, reset value and packing helper for the timer control registers.
// Optional debug-halt feature is enabled by defining TCR_DBG_HALT_EN.
package tcr_pkg;

    localparam int TIMER_EN_BIT = 0;
    localparam int DIV_EN_BIT   = 1;
    localparam int DIV_VAL_LSB  = 8;
    localparam int DIV_VAL_MSB  = 11;

    localparam logic [31:0] TCR_RST   = 32'h0000_0100;
    localparam int          CH_STRIDE = 4;

    typedef struct packed {
        logic [3:0] div_val;
        logic       div_en;
        logic       timer_en;
    } tcr_t;

    localparam tcr_t TCR_RST_FIELDS = '{div_val: 4'd1, div_en: 1'b0, timer_en: 1'b0};

    function automatic logic [31:0] tcr_pack(input tcr_t t);
        logic [31:0] v;
        v = '0;
        v[TIMER_EN_BIT]              = t.timer_en;
        v[DIV_EN_BIT]                = t.div_en;
        v[DIV_VAL_MSB:DIV_VAL_LSB]   = t.div_val;
        return v;
    endfunction

endpackage

// File: rtl/tcr_channel.sv
// One timer channel: control register with write protection, and its count-enable prescaler.
// With TCR_DBG_HALT_EN defined, dbg_halt freezes the prescaler and masks cnt_en.
module tcr_channel
    import tcr_pkg::*;
#(
    parameter int DIV_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic        wr_timer_en,
    input  logic        wr_div_en,
    input  logic [3:0]  wr_div_val,
`ifdef TCR_DBG_HALT_EN
    input  logic        dbg_halt,
`endif
    output logic [31:0] tcr_rd,
    output logic        p_error,
    output logic        cnt_en
);

    localparam logic [3:0] DIV_MAX_L = 4'(DIV_MAX);

    tcr_t tcr_q;
    tcr_t tcr_d;

    logic               halt;
    logic [DIV_MAX-1:0] pcnt_q;
    logic [DIV_MAX-1:0] pcnt_d;
    logic [DIV_MAX-1:0] tc;
    logic               tc_hit;

`ifdef TCR_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    // Once running (or being started) the divider fields are locked; only timer_en may change.
    always_comb begin
        tcr_d   = tcr_q;
        p_error = 1'b0;
        if (wr) begin
            if (tcr_q.timer_en || wr_timer_en) begin
                if ({wr_div_val, wr_div_en} != {tcr_q.div_val, tcr_q.div_en})
                    p_error = 1'b1;
                else
                    tcr_d.timer_en = wr_timer_en;
            end else begin
                if (wr_div_val > DIV_MAX_L) begin
                    p_error = 1'b1;
                end else begin
                    tcr_d.div_en  = wr_div_en;
                    tcr_d.div_val = wr_div_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcr_q <= TCR_RST_FIELDS;
        else
            tcr_q <= tcr_d;
    end

    // div_val never exceeds DIV_MAX, so the terminal count always fits in pcnt.
    assign tc     = DIV_MAX'((32'd1 << tcr_q.div_val) - 32'd1);
    assign tc_hit = (pcnt_q == tc);

    always_comb begin
        pcnt_d = pcnt_q;
        if (!tcr_q.timer_en || !tcr_d.timer_en || !tcr_q.div_en)
            pcnt_d = '0;
        else if (halt)
            pcnt_d = pcnt_q;
        else if (tc_hit)
            pcnt_d = '0;
        else
            pcnt_d = pcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_d;
    end

    assign cnt_en = tcr_q.timer_en & ~halt & (~tcr_q.div_en | tc_hit);
    assign tcr_rd = tcr_pack(tcr_q);

endmodule

// File: rtl/tcr_multi_ch.sv
// Multi-channel timer control block: address decode, read mux and sticky W1C error status.
// Define TCR_DBG_HALT_EN to add the dbg_halt input that freezes all prescalers.
module tcr_multi_ch
    import tcr_pkg::*;
#(
    parameter int          CH_NUM   = 4,
    parameter int          DIV_MAX  = 8,
    parameter logic [11:0] ERR_ADDR = 12'h040
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [11:0]       addr,
    input  logic [31:0]       wr_data,
`ifdef TCR_DBG_HALT_EN
    input  logic              dbg_halt,
`endif
    output logic [31:0]       rd_data,
    output logic              p_error,
    output logic [CH_NUM-1:0] cnt_en,
    output logic              err_irq
);

    logic [CH_NUM-1:0] ch_sel;
    logic [CH_NUM-1:0] ch_perr;
    logic [31:0]       ch_rd [CH_NUM];
    logic              err_sel;
    logic [CH_NUM-1:0] err_clr;
    logic [CH_NUM-1:0] err_q;
    logic [CH_NUM-1:0] err_d;
    logic              unused_wr_data;

    assign unused_wr_data = ^wr_data;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign ch_sel[c] = (addr == 12'(CH_STRIDE * c));

        tcr_channel #(
            .DIV_MAX (DIV_MAX)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr          (wr_en & ch_sel[c]),
            .wr_timer_en (wr_data[TIMER_EN_BIT]),
            .wr_div_en   (wr_data[DIV_EN_BIT]),
            .wr_div_val  (wr_data[DIV_VAL_MSB:DIV_VAL_LSB]),
`ifdef TCR_DBG_HALT_EN
            .dbg_halt    (dbg_halt),
`endif
            .tcr_rd      (ch_rd[c]),
            .p_error     (ch_perr[c]),
            .cnt_en      (cnt_en[c])
        );
    end

    assign err_sel = (addr == ERR_ADDR);
    assign err_clr = (wr_en && err_sel) ? wr_data[CH_NUM-1:0] : '0;
    // A set event in the same cycle as a clear keeps the bit set.
    assign err_d   = (err_q & ~err_clr) | ch_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else
            err_q <= err_d;
    end

    always_comb begin
        rd_data = '0;
        if (err_sel)
            rd_data[CH_NUM-1:0] = err_q;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_sel[c])
                rd_data = ch_rd[c];
        end
    end

    assign p_error = |ch_perr;
    assign err_irq = |err_q;

endmodule
